systolic_output_collector: RTL and testbench
============================================

# systolic_output_collector

Downstream stage of the weight-stationary systolic matmul controller. It captures the column-skewed `bottom_out` words that the controller flags through `output_col_valid`, realigns them into complete result rows, and writes each row to the output-matrix region of RAM, one row per write. It reports completion and sticky overflow to the top-level sequencer.

## Interface
**Parameters**
- `ROWS`, 4: result rows expected per matmul; also buffer depth.
- `COLS`, 4: systolic columns; words per row.
- `WORD_SIZE`, 16: bits per result word.
- `MEM_ACCESS_LATENCY`, 2: clk cycles a RAM write occupies (≥1).
- `OUT_MAT_BASE_ADDR`, 32'h0000_0200: address of result row 0.
- `MEM_ADDR_INCR`, 4: address stride per row.

**Ports**
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high.
- `start`  in  1  arm pulse; clears counters and begins collection.
- `stall`  in  1  controller stall; while high, no samples are captured.
- `matmul_output`  in  COLS*WORD_SIZE  systolic `bottom_out`; column c occupies `[c*WORD_SIZE +: WORD_SIZE]`.
- `output_col_valid`  in  COLS  bit c high means column c holds a valid word this cycle.
- `mem_wr_en`  out  1  one-cycle write strobe.
- `mem_addr`  out  32  write address.
- `mem_wr_data`  out  COLS*WORD_SIZE  row data, column c at `[c*WORD_SIZE +: WORD_SIZE]`.
- `busy`  out  1  high from the accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the last row's write completes.
- `rows_written`  out  $clog2(ROWS)+1  count of rows committed to RAM.
- `overflow_err`  out  1  sticky; a column received more than ROWS samples.

## Operation
- **Buffer.** ROWS×COLS words, plus a per-column receive counter `col_cnt[c]` (0..ROWS).
- **Capture** (any state except IDLE and DONE): on a posedge where `output_col_valid[c] && !stall`:
  - If `col_cnt[c] < ROWS`, store the word at `buf[col_cnt[c]][c]` and increment `col_cnt[c]`.
  - Otherwise drop the word and set `overflow_err`.
- **Row complete.** Row r is complete when `col_cnt[c] > r` for every c.
- **State machine:**
  - IDLE: outputs quiescent. `start` clears `col_cnt`, `rows_written`, `overflow_err` and the write pointer `wr_row`, sets `busy`, and moves to COLLECT.
  - COLLECT: when row `wr_row` is complete, move to WRITE.
  - WRITE: hold one cycle with `mem_wr_en`=1, `mem_addr = OUT_MAT_BASE_ADDR + wr_row*MEM_ADDR_INCR`, and `mem_wr_data = buf[wr_row]`. Then increment `wr_row` and `rows_written`. Go to WAIT if `MEM_ACCESS_LATENCY>1`, otherwise take the WAIT exit immediately.
  - WAIT: count `MEM_ACCESS_LATENCY-1` cycles. Then go to DONE if `rows_written==ROWS`, otherwise to COLLECT.
  - DONE: one cycle with `done`=1 and `busy`=0; then return to IDLE.
- **Concurrency.** Capture continues during WRITE and WAIT. A capture and a write in the same cycle never conflict, because the row being written is already complete.
- **Arithmetic.** Addresses are computed in 32-bit unsigned arithmetic; wrap-around is not checked.
- **Start handling.** `start` is ignored outside IDLE.
- **Invalid columns.** Columns with valid low are ignored regardless of data.
- **Reset.** `rst` at any time, including mid-write, returns to IDLE on the next posedge. No further `mem_wr_en` is issued and buffer contents become don't-care.

## Timing
- **Reset values:** `mem_wr_en`=0, `mem_addr`=0, `mem_wr_data`=0, `busy`=0, `done`=0, `rows_written`=0, `overflow_err`=0.
- **Arming:** `busy` rises the cycle after `start` is sampled.
- **Write latency:** `mem_wr_en` for row r is asserted at the earliest 1 cycle after the posedge that captured the last missing column of row r. If a write is in progress, it follows that write's WAIT.
- **Write spacing:** consecutive writes are exactly MEM_ACCESS_LATENCY+1 cycles apart when rows are already complete (WRITE, WAIT, COLLECT).
- **Completion:** `done` pulses MEM_ACCESS_LATENCY cycles after the last WRITE cycle.
- **Sampling edge:** valid/data are sampled on posedge. The upstream FSM updates `output_col_valid` on negedge, so the inputs are stable at posedge.
- **Output hold:** `mem_addr` and `mem_wr_data` hold their last values outside WRITE.

## Test plan
- **Aligned stream.** ROWS=COLS=2, latency 2. After `start`, drive col0 valid on cycles 1–2 and col1 valid on cycles 2–3, with data encoding row/column. Expect writes 0x0200 then 0x0204 carrying the correct rows, `rows_written`=2, then a `done` pulse.
- **Skewed 4×4.** ROWS=COLS=4. Column c is valid for 4 cycles starting at cycle c. Expect 4 writes at addresses 0x200–0x20C, at least 3 cycles apart, row data exactly realigned.
- **Stall.** Same stimulus as the skewed 4×4 case, with `stall`=1 for 2 cycles mid-stream while valid is held. Stalled samples are not captured. Expect writes identical to an unstalled run that presents the same valid samples, only later.
- **Overflow.** Drive a fifth valid on col0 with ROWS=4. Expect `overflow_err`=1 (sticky until the next `start`) and the buffered data unchanged.
- **Reset mid-write.** Assert `rst` during WAIT after the row-1 write. Expect no further `mem_wr_en`, all outputs at reset values, and a fresh `start` producing a full correct run.
- **Start while busy.** Pulse `start` during COLLECT. Expect no counter clear and normal completion.

Source files
------------

// File: rtl/systolic_output_collector.sv
// ---------------------------------------------------------------------------
// systolic_output_collector
//   Captures column-skewed systolic bottom_out words, realigns them into full
//   result rows and writes each completed row to the output-matrix RAM region,
//   one row per write strobe.
//
//   clk, rst            clock, synchronous active-high reset
//   start               arm pulse (only honoured while idle)
//   stall               controller stall; suppresses capture
//   matmul_output       COLS words, column c at [c*WORD_SIZE +: WORD_SIZE]
//   output_col_valid    per-column valid for matmul_output
//   mem_wr_en           one-cycle RAM write strobe
//   mem_addr            write address (held between writes)
//   mem_wr_data         row data, column c at [c*WORD_SIZE +: WORD_SIZE]
//   busy                high while collecting/writing
//   done                one-cycle pulse after the last row's write completes
//   rows_written        rows committed this matmul
//   overflow_err        sticky: some column got more than ROWS samples
// ---------------------------------------------------------------------------
module systolic_output_collector #(
   parameter int unsigned ROWS               = 4,
   parameter int unsigned COLS               = 4,
   parameter int unsigned WORD_SIZE          = 16,
   parameter int unsigned MEM_ACCESS_LATENCY = 2,
   parameter logic [31:0] OUT_MAT_BASE_ADDR  = 32'h0000_0200,
   parameter int unsigned MEM_ADDR_INCR      = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      stall,
   input  logic [COLS*WORD_SIZE-1:0] matmul_output,
   input  logic [COLS-1:0]           output_col_valid,
   output logic                      mem_wr_en,
   output logic [31:0]               mem_addr,
   output logic [COLS*WORD_SIZE-1:0] mem_wr_data,
   output logic                      busy,
   output logic                      done,
   output logic [$clog2(ROWS):0]     rows_written,
   output logic                      overflow_err
);

   localparam int CW       = $clog2(ROWS) + 1;              // counts 0..ROWS
   localparam int RW       = (ROWS > 1) ? $clog2(ROWS) : 1; // row index
   localparam int WAIT_CYC = int'(MEM_ACCESS_LATENCY) - 1;
   localparam int WW       = $clog2(MEM_ACCESS_LATENCY) + 1;

   typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_WAIT, S_DONE} state_t;

   state_t                               state, state_nxt;
   logic [CW-1:0]                        wr_row;
   logic [CW-1:0]                        rows_written_inc;
   logic [WW-1:0]                        wait_cnt;
   logic                                 cap_en;
   logic                                 clr;
   logic                                 row_done;
   logic [COLS-1:0]                      col_rdy;
   logic [COLS-1:0]                      col_ovf;
   logic [ROWS-1:0][COLS*WORD_SIZE-1:0]  row_data;

   assign cap_en           = (state == S_COLLECT || state == S_WRITE || state == S_WAIT) && !stall;
   assign clr              = (state == S_IDLE) && start;
   assign rows_written_inc = rows_written + CW'(1);
   assign row_done         = &col_rdy;

   // Per-column capture: each column fills its own word list in arrival
   // order, so the n-th accepted sample of a column lands in row n.
   for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [CW-1:0]                  cnt;
      logic [ROWS-1:0][WORD_SIZE-1:0] words;
      logic                           take;
      logic                           room;

      assign take = cap_en && output_col_valid[c];
      assign room = cnt < CW'(ROWS);

      always_ff @(posedge clk) begin
         if (rst || clr)
            cnt <= '0;
         else if (take && room)
            cnt <= cnt + CW'(1);
      end

      // Storage needs no reset; rows are only read once their counters say so.
      always_ff @(posedge clk) begin
         if (take && room)
            words[cnt[RW-1:0]] <= matmul_output[c*WORD_SIZE +: WORD_SIZE];
      end

      assign col_rdy[c] = cnt > wr_row;
      assign col_ovf[c] = take && !room;

      for (genvar r = 0; r < ROWS; r++) begin : g_row
         assign row_data[r][c*WORD_SIZE +: WORD_SIZE] = words[r];
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      mem_wr_en = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start)
               state_nxt = S_COLLECT;
         end
         S_COLLECT: begin
            busy = 1'b1;
            if (row_done)
               state_nxt = S_WRITE;
         end
         S_WRITE: begin
            busy      = 1'b1;
            mem_wr_en = 1'b1;
            // Single-cycle RAM: skip WAIT and decide on the post-write count.
            if (WAIT_CYC > 0)
               state_nxt = S_WAIT;
            else if (rows_written_inc == CW'(ROWS))
               state_nxt = S_DONE;
            else
               state_nxt = S_COLLECT;
         end
         S_WAIT: begin
            busy = 1'b1;
            if (wait_cnt == WW'(1))
               state_nxt = (rows_written == CW'(ROWS)) ? S_DONE : S_COLLECT;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_row       <= '0;
         rows_written <= '0;
         overflow_err <= 1'b0;
         wait_cnt     <= '0;
         mem_addr     <= '0;
         mem_wr_data  <= '0;
      end else begin
         if (clr) begin
            wr_row       <= '0;
            rows_written <= '0;
            overflow_err <= 1'b0;
         end else begin
            if (|col_ovf)
               overflow_err <= 1'b1;
            if (state == S_WRITE) begin
               wr_row       <= wr_row + CW'(1);
               rows_written <= rows_written_inc;
            end
         end
         // Address/data are registered on entry to WRITE and then held until
         // the next write, so the RAM sees stable values outside the strobe.
         if (state == S_COLLECT && row_done) begin
            mem_addr    <= OUT_MAT_BASE_ADDR + 32'(wr_row) * 32'(MEM_ADDR_INCR);
            mem_wr_data <= row_data[wr_row[RW-1:0]];
         end
         if (state == S_WRITE)
            wait_cnt <= WW'(WAIT_CYC);
         else if (state == S_WAIT)
            wait_cnt <= wait_cnt - WW'(1);
      end
   end

endmodule

// File: tb/tb_systolic_output_collector.sv
// ---------------------------------------------------------------------------
// tb_systolic_output_collector
//   Random skewed column streams (holes, stalls, overflow, start-while-busy,
//   reset mid-write). The driver derives each expected row write from the
//   samples it knows were accepted and queues it; a negedge monitor pops and
//   compares every write strobe and every done pulse.
// ---------------------------------------------------------------------------
module tb_systolic_output_collector;

   localparam int          ROWS = 4;
   localparam int          COLS = 4;
   localparam int          WS   = 16;
   localparam int          LAT  = 2;
   localparam logic [31:0] BASE = 32'h0000_0200;
   localparam int          INCR = 4;
   localparam int          DW   = COLS * WS;

   logic                   clk = 1'b0;
   logic                   rst, start, stall;
   logic [DW-1:0]          mo;
   logic [COLS-1:0]        vld;
   logic                   mem_wr_en, busy, done, overflow_err;
   logic [31:0]            mem_addr;
   logic [DW-1:0]          mem_wr_data;
   logic [$clog2(ROWS):0]  rows_written;

   systolic_output_collector #(
      .ROWS(ROWS), .COLS(COLS), .WORD_SIZE(WS), .MEM_ACCESS_LATENCY(LAT),
      .OUT_MAT_BASE_ADDR(BASE), .MEM_ADDR_INCR(INCR)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .stall(stall),
      .matmul_output(mo), .output_col_valid(vld),
      .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
      .busy(busy), .done(done), .rows_written(rows_written),
      .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   int cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   typedef struct {
      logic [31:0]   addr;
      logic [DW-1:0] data;
      int            rdy;   // negedge cycle at which the row's last word was driven
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp    = 0;
   int   n_bad    = 0;
   int   done_cnt = 0;
   int   last_wr  = -1;
   int   wr1_cyc  = -1;
   bit   run_active = 1'b0;
   bit   exp_ovf    = 1'b0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cycle);
      end
   endtask

   // Monitor: every write strobe must match the head of the queue, both in
   // content and in the cycle it appears.
   exp_t e_m;
   int   ex_cyc;
   always @(negedge clk) begin
      if (mem_wr_en) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", 1, 0);
         end else begin
            e_m = exp_q.pop_front();
            check("wr_addr", mem_addr, e_m.addr);
            check("wr_data", mem_wr_data, e_m.data);
            ex_cyc = e_m.rdy + 2;
            if (last_wr >= 0 && last_wr + LAT + 1 > ex_cyc)
               ex_cyc = last_wr + LAT + 1;
            check("wr_cycle", cycle, ex_cyc);
            if (e_m.addr == BASE + INCR)
               wr1_cyc = cycle;
            last_wr = cycle;
         end
      end
      if (done) begin
         done_cnt++;
         check("done_in_run", run_active, 1);
         check("done_delay", cycle - last_wr, LAT);
         check("done_rows_written", rows_written, ROWS);
         check("done_busy", busy, 0);
         check("done_overflow", overflow_err, exp_ovf);
         check("done_rows_pending", exp_q.size(), 0);
         run_active = 1'b0;
      end
   end

   task automatic check_reset_values();
      check("rst_wr_en", mem_wr_en, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_data", mem_wr_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rows_written", rows_written, 0);
      check("rst_overflow", overflow_err, 0);
   endtask

   // One matmul. Column c may present data from cycle c onward; hole_pct is
   // the chance a column idles in a cycle, stalls randomly block capture.
   task automatic run(input int hole_pct, input bit do_stall, input bit do_ovf,
                      input bit do_sb, input bit do_rst);
      logic [WS-1:0] w [COLS][ROWS];
      logic [DW-1:0] row;
      int            ptr [COLS];
      int            nxt, cyc, sb_cyc, d0, t;
      bit            all_in;
      exp_t          e;

      for (int c = 0; c < COLS; c++) begin
         ptr[c] = 0;
         for (int r = 0; r < ROWS; r++) w[c][r] = WS'($urandom);
      end
      nxt = 0;
      @(negedge clk);
      check("busy_idle", busy, 0);
      last_wr = -1;
      wr1_cyc = -1;
      exp_ovf = 1'b0;
      d0      = done_cnt;
      start   = 1'b1;
      @(negedge clk);
      start      = 1'b0;
      run_active = 1'b1;
      check("busy_armed", busy, 1);
      check("rows_cleared", rows_written, 0);
      check("ovf_cleared", overflow_err, 0);

      sb_cyc = do_sb ? $urandom_range(1, 5) : -1;
      cyc    = 0;
      while (nxt < ROWS && cyc < 500) begin
         stall = do_stall && ($urandom_range(0, 4) == 0);
         start = (cyc == sb_cyc);
         for (int c = 0; c < COLS; c++) begin
            if (ptr[c] < ROWS && cyc >= c && $urandom_range(0, 99) >= hole_pct) begin
               vld[c]          = 1'b1;
               mo[c*WS +: WS]  = w[c][ptr[c]];
            end else begin
               vld[c]          = 1'b0;
               mo[c*WS +: WS]  = WS'($urandom);
            end
         end
         if (!stall)
            for (int c = 0; c < COLS; c++) if (vld[c]) ptr[c]++;
         // A row is due once every column has delivered at least nxt+1 words.
         forever begin
            all_in = (nxt < ROWS);
            for (int c = 0; c < COLS; c++) if (ptr[c] <= nxt) all_in = 1'b0;
            if (!all_in) break;
            for (int c = 0; c < COLS; c++) row[c*WS +: WS] = w[c][nxt];
            e.addr = BASE + 32'(nxt * INCR);
            e.data = row;
            e.rdy  = cycle;
            exp_q.push_back(e);
            nxt++;
         end
         @(negedge clk);
         cyc++;
      end
      vld   = '0;
      stall = 1'b0;
      start = 1'b0;

      if (do_ovf) begin
         vld[0]     = 1'b1;
         mo[0 +: WS] = WS'($urandom);
         exp_ovf    = 1'b1;
         @(negedge clk);
         vld = '0;
      end

      if (do_rst) begin
         t = 0;
         while (!(wr1_cyc >= 0 && cycle >= wr1_cyc + 1) && t < 100) begin
            @(negedge clk);
            t++;
         end
         check("rst_reached_wait", (t < 100), 1);
         rst = 1'b1;
         @(negedge clk);
         rst        = 1'b0;
         run_active = 1'b0;
         exp_q.delete();
         check_reset_values();
         repeat (10) @(negedge clk);
         check("no_done_after_rst", done_cnt, d0);
      end else begin
         t = 0;
         while (done_cnt == d0 && t < 100) begin
            @(negedge clk);
            t++;
         end
         check("done_seen", done_cnt, d0 + 1);
         check("ovf_sticky", overflow_err, exp_ovf);
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      stall = 1'b0;
      vld   = '0;
      mo    = '0;
      repeat (3) @(negedge clk);
      check_reset_values();
      rst = 1'b0;

      run(0, 1'b0, 1'b0, 1'b0, 1'b0);                       // clean skewed stream
      repeat (3) run(20, 1'b0, 1'b0, 1'b0, 1'b0);           // random holes
      run(0, 1'b1, 1'b0, 1'b0, 1'b0);                       // stalls
      repeat (2) run(20, 1'b1, 1'b0, 1'b0, 1'b0);           // stalls + holes
      run(10, 1'b0, 1'b1, 1'b0, 1'b0);                      // overflow on col0
      run(0, 1'b0, 1'b0, 1'b0, 1'b0);                       // overflow cleared by start
      run(0, 1'b0, 1'b0, 1'b1, 1'b0);                       // start while busy
      run(0, 1'b0, 1'b0, 1'b0, 1'b1);                       // reset during WAIT
      run(15, 1'b1, 1'b0, 1'b0, 1'b0);                      // fresh run after reset

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
